ram_sequencer: RTL

- Parametrised single-port synchronous RAM with an internal auto-incrementing address counter and a mode-driven controller.
- Replaces hand-clocked RAM plus external counter setups on the board.
- Supports bulk clear, paced write passes and paced read passes, with busy/done/valid status for display and game logic.
- Intended to be paced by a rate_divider enable on `step`.

---
 rtl/ram_sequencer_if.sv | 29 ++
 rtl/ram_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ram_sequencer_if.sv
// Bus bundle for ram_sequencer: control inputs from the pacing/game logic and
// address/data/status outputs back to it. Clock and reset stay plain ports.
interface ram_sequencer_if #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 5
);
    logic                  start;
    logic [1:0]            mode;
    logic                  abort;
    logic                  step;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;
    logic                  done;

    // Controller side: issues commands, watches status
    modport master (
        output start, mode, abort, step, wr_data,
        input  address, q, q_valid, busy, done
    );

    // Sequencer side
    modport slave (
        input  start, mode, abort, step, wr_data,
        output address, q, q_valid, busy, done
    );
endinterface

// File: rtl/ram_sequencer.sv
// Single-port synchronous RAM with an auto-incrementing address counter.
// Modes: rewind, bulk clear (free-running), paced write pass, paced read pass.
// A pass always runs from address 0 to LAST_ADDR, then returns to IDLE with a
// one-cycle done pulse; abort drops back to IDLE silently.
module ram_sequencer #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 5,
    parameter int LAST_ADDR  = 31
) (
    input  logic             clock,
    input  logic             resetn,
    ram_sequencer_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_READ  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] q_q,       q_d;
    logic                  q_valid_q, q_valid_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic                  pass_adv;

    // Next-state, counter and RAM strobe decode
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        q_valid_d = 1'b0;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        pass_adv  = 1'b0;

        if (state_q == S_IDLE) begin
            // abort also masks a start in IDLE
            if (bus.start && !bus.abort) begin
                address_d = '0;
                case (bus.mode)
                    2'b00:   done_d  = 1'b1;
                    2'b01:   state_d = S_CLEAR;
                    2'b10:   state_d = S_WRITE;
                    default: state_d = S_READ;
                endcase
            end
        end else if (bus.abort) begin
            // abort wins over step: no write, no read, no done
            state_d   = S_IDLE;
            address_d = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    mem_we   = 1'b1;
                    pass_adv = 1'b1;
                end
                S_WRITE: begin
                    if (bus.step) begin
                        mem_we    = 1'b1;
                        mem_wdata = bus.wr_data;
                        pass_adv  = 1'b1;
                    end
                end
                default: begin
                    if (bus.step) begin
                        mem_re    = 1'b1;
                        q_valid_d = 1'b1;
                        pass_adv  = 1'b1;
                    end
                end
            endcase

            if (pass_adv) begin
                if (address_q == LAST) begin
                    address_d = '0;
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                end else begin
                    address_d = address_q + ONE;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
        q_d    = mem_re ? mem[address_q] : q_q;
    end

    // Control and status registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            address_q <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // RAM array write port; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) mem[address_q] <= mem_wdata;
    end

    assign bus.address = address_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
